// File: rtl/dmem_resp.sv
// MEM-stage data-memory responder: byte-enabled stores, multi-cycle stalled loads with
// alignment/extension, and registered MEM/WB writeback. Optional macro: DMEM_MISALIGN_CHK_EN.
module dmem_resp #(
   parameter int unsigned DEPTH       = 4096,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_raddr_i,
   input  logic [31:0] mem_waddr_i,
   input  logic [31:0] mem_wdata_i,
   input  logic [2:0]  mem_funct3_i,
   input  logic [31:0] reg_wdata_i,
   input  logic        reg_we_i,
   input  logic [4:0]  reg_waddr_i,
   output logic        hold_o,
   output logic [31:0] wb_data_o,
   output logic        wb_we_o,
   output logic [4:0]  wb_addr_o,
   output logic        misalign_o,
   output logic [31:0] misalign_addr_o
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [2:0]  WaitInit = 3'(WAIT_CYCLES);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StWait = 1'b1;

   logic [0:0]    state_q;
   logic [2:0]    cnt_q;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;
   logic [4:0]    rd_q;
   logic          rd_we_q;
   logic [31:0]   rdata_q;

   logic [31:0]   ram [DEPTH];

   logic          idle;
   logic          misalign;
   logic          load_acc;
   logic          store_acc;
   logic [AW-1:0] ridx;
   logic [AW-1:0] widx;
   logic [3:0]    be;
   logic [31:0]   wdata_rep;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   ld_data;
   logic          unused_addr;

   // Upper address bits alias by design.
   assign unused_addr = ^{mem_raddr_i[31:AW+2], mem_waddr_i[31:AW+2]};

   assign idle      = (state_q == StIdle);
   assign ridx      = mem_raddr_i[AW+1:2];
   assign widx      = mem_waddr_i[AW+1:2];
   assign load_acc  = ~rst & idle & mem_req_i & ~mem_we_i & ~misalign;
   assign store_acc = ~rst & idle & mem_req_i & mem_we_i & ~misalign;
   assign hold_o    = load_acc | (~rst & (state_q == StWait));

`ifdef DMEM_MISALIGN_CHK_EN
   logic [31:0] acc_addr;
   logic        mis_raw;
   logic        mis_q;
   logic [31:0] mis_addr_q;

   always_comb begin
      acc_addr = mem_we_i ? mem_waddr_i : mem_raddr_i;
      case (mem_funct3_i)
         3'b000, 3'b100: mis_raw = 1'b0;
         3'b001, 3'b101: mis_raw = acc_addr[0];
         default:        mis_raw = |acc_addr[1:0];
      endcase
   end

   assign misalign = ~rst & idle & mem_req_i & mis_raw;

   always_ff @(posedge clk) begin
      if (rst) begin
         mis_q      <= 1'b0;
         mis_addr_q <= 32'h0;
      end else begin
         mis_q <= misalign;
         if (misalign) begin
            mis_addr_q <= acc_addr;
         end
      end
   end

   assign misalign_o      = mis_q;
   assign misalign_addr_o = mis_addr_q;
`else
   assign misalign        = 1'b0;
   assign misalign_o      = 1'b0;
   assign misalign_addr_o = 32'h0;
`endif

   // Store lane selection; data is replicated so every enabled lane sees the right bytes.
   always_comb begin
      case (mem_funct3_i)
         3'b000, 3'b100: begin
            be        = 4'b0001 << mem_waddr_i[1:0];
            wdata_rep = {4{mem_wdata_i[7:0]}};
         end
         3'b001, 3'b101: begin
            be        = mem_waddr_i[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{mem_wdata_i[15:0]}};
         end
         default: begin
            be        = 4'b1111;
            wdata_rep = mem_wdata_i;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (store_acc) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               ram[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
         end
      end
      if (load_acc) begin
         rdata_q <= ram[ridx];
      end
   end

   always_comb begin
      ld_byte = rdata_q[{off_q, 3'b000} +: 8];
      ld_half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (f3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'h0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'h0, ld_half};
         default: ld_data = rdata_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= 3'd0;
         f3_q      <= 3'd0;
         off_q     <= 2'd0;
         rd_q      <= 5'd0;
         rd_we_q   <= 1'b0;
         wb_data_o <= 32'h0;
         wb_we_o   <= 1'b0;
         wb_addr_o <= 5'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (misalign) begin
                  wb_we_o <= 1'b0;
               end else if (load_acc) begin
                  f3_q    <= mem_funct3_i;
                  off_q   <= mem_raddr_i[1:0];
                  rd_q    <= reg_waddr_i;
                  rd_we_q <= reg_we_i;
                  cnt_q   <= WaitInit;
                  wb_we_o <= 1'b0;
                  state_q <= StWait;
               end else begin
                  wb_data_o <= reg_wdata_i;
                  wb_we_o   <= reg_we_i;
                  wb_addr_o <= reg_waddr_i;
               end
            end
            StWait: begin
               if (cnt_q != 3'd0) begin
                  cnt_q   <= cnt_q - 3'd1;
                  wb_we_o <= 1'b0;
               end else begin
                  wb_data_o <= ld_data;
                  wb_we_o   <= rd_we_q;
                  wb_addr_o <= rd_q;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed self-checking bench for dmem_resp (WAIT_CYCLES=1, DEPTH=1024 so addresses alias at
// 4 KiB). Honours DMEM_MISALIGN_CHK_EN when defined for both bench and design.
module tb_dmem_resp;

   localparam int unsigned Depth = 1024;
   localparam int unsigned Wait  = 1;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_raddr;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_funct3;
   logic [31:0] reg_wdata;
   logic        reg_we;
   logic [4:0]  reg_waddr;
   logic        hold;
   logic [31:0] wb_data;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic        misalign;
   logic [31:0] misalign_addr;

   int checks = 0;
   int errors = 0;

   dmem_resp #(
      .DEPTH       (Depth),
      .WAIT_CYCLES (Wait)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .mem_req_i       (mem_req),
      .mem_we_i        (mem_we),
      .mem_raddr_i     (mem_raddr),
      .mem_waddr_i     (mem_waddr),
      .mem_wdata_i     (mem_wdata),
      .mem_funct3_i    (mem_funct3),
      .reg_wdata_i     (reg_wdata),
      .reg_we_i        (reg_we),
      .reg_waddr_i     (reg_waddr),
      .hold_o          (hold),
      .wb_data_o       (wb_data),
      .wb_we_o         (wb_we),
      .wb_addr_o       (wb_addr),
      .misalign_o      (misalign),
      .misalign_addr_o (misalign_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_in();
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      reg_we    = 1'b0;
      reg_wdata = 32'h0;
      reg_waddr = 5'd0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
      mem_req    = 1'b1;
      mem_we     = 1'b1;
      mem_waddr  = a;
      mem_wdata  = d;
      mem_funct3 = f3;
      reg_we     = 1'b0;
      #1;
      chk("st_hold", {31'b0, hold}, 32'd0);
      tick();
      idle_in();
   endtask

   task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] exp);
      mem_req    = 1'b1;
      mem_we     = 1'b0;
      mem_raddr  = a;
      mem_funct3 = f3;
      reg_waddr  = rd;
      reg_we     = 1'b1;
      #1;
      chk({tag, "_hold_t0"}, {31'b0, hold}, 32'd1);
      for (int i = 0; i < Wait + 1; i++) begin
         tick();
         chk({tag, "_hold_wait"}, {31'b0, hold}, 32'd1);
         chk({tag, "_we_bubble"}, {31'b0, wb_we}, 32'd0);
      end
      tick();
      idle_in();
      #1;
      chk({tag, "_hold_end"}, {31'b0, hold}, 32'd0);
      chk({tag, "_we"}, {31'b0, wb_we}, 32'd1);
      chk({tag, "_addr"}, {27'b0, wb_addr}, {27'b0, rd});
      chk({tag, "_data"}, wb_data, exp);
   endtask

   initial begin
      rst        = 1'b1;
      mem_raddr  = 32'h0;
      mem_waddr  = 32'h0;
      mem_wdata  = 32'h0;
      mem_funct3 = 3'b010;
      idle_in();
      tick();
      tick();
      chk("rst_hold", {31'b0, hold}, 32'd0);
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_wb_we", {31'b0, wb_we}, 32'd0);
      chk("rst_wb_addr", {27'b0, wb_addr}, 32'd0);
      chk("rst_mis", {31'b0, misalign}, 32'd0);
      chk("rst_mis_addr", misalign_addr, 32'h0);
      rst = 1'b0;

      // Word store/load round trip.
      do_store(32'h100, 3'b010, 32'hDEADBEEF);
      do_load("lw_100", 32'h100, 3'b010, 5'd5, 32'hDEADBEEF);

      // Byte store into a known word, then byte loads and untouched lanes.
      do_store(32'h200, 3'b010, 32'h11223344);
      do_store(32'h203, 3'b000, 32'h00000080);
      do_load("lb_203", 32'h203, 3'b000, 5'd6, 32'hFFFFFF80);
      do_load("lbu_203", 32'h203, 3'b100, 5'd6, 32'h00000080);
      do_load("lw_200", 32'h200, 3'b010, 5'd6, 32'h80223344);
      do_load("lb_200", 32'h200, 3'b000, 5'd6, 32'h00000044);

      // Halfword store into upper half of 0x100.
      do_store(32'h102, 3'b001, 32'h00008001);
      do_load("lh_102", 32'h102, 3'b001, 5'd8, 32'hFFFF8001);
      do_load("lhu_102", 32'h102, 3'b101, 5'd8, 32'h00008001);
      do_load("lh_100", 32'h100, 3'b001, 5'd8, 32'hFFFFBEEF);
      do_load("lw_100b", 32'h100, 3'b010, 5'd8, 32'h8001BEEF);
      do_load("lw_alias", 32'h1100, 3'b010, 5'd10, 32'h8001BEEF);

      // Non-memory passthrough.
      reg_wdata = 32'h1234;
      reg_waddr = 5'd7;
      reg_we    = 1'b1;
      #1;
      chk("pt_hold", {31'b0, hold}, 32'd0);
      tick();
      idle_in();
      chk("pt_data", wb_data, 32'h1234);
      chk("pt_we", {31'b0, wb_we}, 32'd1);
      chk("pt_addr", {27'b0, wb_addr}, 32'd7);

      // Reset during WAIT aborts the load.
      mem_req    = 1'b1;
      mem_we     = 1'b0;
      mem_raddr  = 32'h100;
      mem_funct3 = 3'b010;
      reg_waddr  = 5'd9;
      reg_we     = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_in();
      #1;
      chk("abort_hold", {31'b0, hold}, 32'd0);
      chk("abort_we", {31'b0, wb_we}, 32'd0);
      tick();
      chk("abort_we2", {31'b0, wb_we}, 32'd0);
      chk("abort_data", wb_data, 32'h0);

      // Store then load of the same word in the next cycle; reserved funct3 acts as W.
      do_store(32'h300, 3'b010, 32'hCAFEF00D);
      do_load("lw_fwd", 32'h300, 3'b010, 5'd11, 32'hCAFEF00D);
      do_load("lw_rsv", 32'h300, 3'b011, 5'd12, 32'hCAFEF00D);

      // Misaligned word store.
      mem_req    = 1'b1;
      mem_we     = 1'b1;
      mem_waddr  = 32'h101;
      mem_wdata  = 32'h55667788;
      mem_funct3 = 3'b010;
      reg_we     = 1'b1;
      reg_waddr  = 5'd3;
      reg_wdata  = 32'hAA;
      tick();
      idle_in();
`ifdef DMEM_MISALIGN_CHK_EN
      chk("mis_st_pulse", {31'b0, misalign}, 32'd1);
      chk("mis_st_addr", misalign_addr, 32'h101);
      chk("mis_st_we", {31'b0, wb_we}, 32'd0);
      tick();
      chk("mis_st_fall", {31'b0, misalign}, 32'd0);
      do_load("mis_st_ram", 32'h100, 3'b010, 5'd4, 32'h8001BEEF);
      mem_req    = 1'b1;
      mem_we     = 1'b0;
      mem_raddr  = 32'h101;
      mem_funct3 = 3'b001;
      reg_we     = 1'b1;
      reg_waddr  = 5'd4;
      #1;
      chk("mis_ld_hold", {31'b0, hold}, 32'd0);
      tick();
      idle_in();
      chk("mis_ld_pulse", {31'b0, misalign}, 32'd1);
      chk("mis_ld_addr", misalign_addr, 32'h101);
      chk("mis_ld_we", {31'b0, wb_we}, 32'd0);
`else
      chk("mis_st_pulse", {31'b0, misalign}, 32'd0);
      chk("mis_st_addr", misalign_addr, 32'h0);
      chk("mis_st_we", {31'b0, wb_we}, 32'd1);
      do_load("mis_st_ram", 32'h100, 3'b010, 5'd4, 32'h55667788);
      do_load("mis_lh_103", 32'h103, 3'b001, 5'd4, 32'h00005566);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder: the MEM-stage slave that services the memory requests registered by the EX/MEM pipeline register. It holds a word-organised synchronous data RAM and executes stores with byte enables. Loads use a fixed multi-cycle read with a stall (`hold_o`) back to the pipeline, and the loaded byte, halfword or word is aligned and sign- or zero-extended. It also forwards non-load register writebacks, producing the registered MEM/WB writeback triple.

## Interface
Parameters:
- `DEPTH`, 4096: RAM size in 32-bit words; power of two.
- `WAIT_CYCLES`, 1: extra read wait states, 0..7.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `mem_req_i`  in  1  memory access request.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_raddr_i`  in  32  load byte address.
- `mem_waddr_i`  in  32  store byte address.
- `mem_wdata_i`  in  32  store data, LSB-aligned.
- `mem_funct3_i`  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `reg_wdata_i`  in  32  non-load writeback data.
- `reg_we_i`  in  1  writeback enable.
- `reg_waddr_i`  in  5  writeback register.
- `hold_o`  out  1  stall request to upstream stages.
- `wb_data_o`  out  32  writeback data.
- `wb_we_o`  out  1  writeback enable.
- `wb_addr_o`  out  5  writeback register.
- `misalign_o`  out  1  misaligned-access pulse; only live under the macro.
- `misalign_addr_o`  out  32  offending address.

## Operation
- FSM states are IDLE and WAIT. New requests are accepted only in IDLE.
- RAM index is `addr[$clog2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses alias modulo 4·DEPTH bytes.
- Store, accepted in IDLE with `mem_req_i`=1 and `mem_we_i`=1:
  - byte enables: SB writes lane `addr[1:0]`; SH writes lanes {1,0} or {3,2} selected by `addr[1]`; SW writes all lanes.
  - store data is replicated onto the selected lanes.
  - no stall; state stays IDLE.
  - the writeback triple passes through as for a non-memory op.
- Load, accepted in IDLE with `mem_req_i`=1 and `mem_we_i`=0:
  - latch `funct3`, `addr[1:0]`, `reg_waddr_i` and `reg_we_i`.
  - issue the RAM read, go to WAIT with `cnt`=`WAIT_CYCLES`.
- In WAIT: if `cnt`≠0, decrement `cnt`. If `cnt`=0, format the RAM output, register it into `wb_*` and return to IDLE.
- Load formatting:
  - B/BU: byte at lane `addr[1:0]`, sign- or zero-extended.
  - H/HU: halfword selected by `addr[1]`, sign- or zero-extended.
  - W: full word.
- `hold_o` = (IDLE & load accept) | WAIT. It is combinational in the accept cycle.
- In WAIT, inputs are ignored and `wb_we_o`=0 (bubble).
- Non-memory op (`mem_req_i`=0): `wb_*` ← `reg_*_i` on the next edge.
- Reserved `funct3` codes are treated as W.
- RAM contents are not reset.

## Timing
- Reset values: state IDLE, `cnt` 0, `hold_o` 0, `wb_data_o` 0, `wb_we_o` 0, `wb_addr_o` 0, `misalign_o` 0, `misalign_addr_o` 0.
- Reset asserted mid-load aborts the load; no writeback is produced.
- Store accepted in cycle T: RAM is updated at the T→T+1 edge.
- Passthrough writeback: visible at T+1.
- Load accepted in cycle T:
  - `hold_o`=1 during cycles T..T+WAIT_CYCLES+1, i.e. WAIT_CYCLES+2 cycles.
  - `wb_we_o` pulses for one cycle at T+WAIT_CYCLES+2, and the block is back in IDLE in that same cycle.
  - upstream holds its request stable while `hold_o`=1.
- Store at T followed by a load of the same word at T+1 returns the new data; there is no read-before-write hazard.
- Back-to-back loads: the second is accepted at T+WAIT_CYCLES+2.

## Configuration
- Macro: `DMEM_MISALIGN_CHK_EN`.
- Defined:
  - misaligned means H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
  - a misaligned store performs no RAM write.
  - a misaligned load does not stall and does not enter WAIT.
  - for either, `wb_we_o`=0 at T+1, `misalign_o` pulses 1 at T+1, and `misalign_addr_o` holds the byte address.
- Undefined:
  - `misalign_o` and `misalign_addr_o` are tied to 0.
  - misaligned accesses ignore the offending low bits: H uses `addr[1]` only, W ignores `addr[1:0]`.

## Test plan
- Reset with `WAIT_CYCLES`=1, then SW of 0xDEADBEEF to 0x100, then LW x5 from 0x100 → `hold_o` high for 3 cycles; `wb_we_o`=1, `wb_addr_o`=5 and `wb_data_o`=0xDEADBEEF at T+3.
- SB 0x80 to 0x203, then LB and LBU from 0x203 → 0xFFFFFF80 and 0x00000080; the other lanes of word 0x200 are unchanged.
- SH 0x8001 to 0x102, then LH and LHU from 0x102 → 0xFFFF8001 and 0x00008001.
- Non-memory op with `reg_wdata_i`=0x1234 and `reg_waddr_i`=7 → `wb_*` reflects these at T+1 with no stall.
- Assert `rst` in the WAIT cycle of a load → `hold_o` and `wb_we_o` are 0 on the next cycle, and no writeback occurs.
- With `DMEM_MISALIGN_CHK_EN` defined, SW to 0x101 → no RAM change, `misalign_o`=1 and `misalign_addr_o`=0x101 at T+1. With the macro undefined, the same store writes word 0x100.
